// File: rtl/ex_stage_unit_if.sv
// Purpose: bundles the ID/EX inputs, forwarding sources and EX/MEM outputs of the EX stage.
// Latency: none, wiring only.
// Backpressure: Stall travels back to the upstream stages through this bundle.
interface ex_stage_unit_if #(
  parameter int DATA_W = 32
);
  // ID/EX pipeline fields
  logic [1:0]        WBIn;
  logic [1:0]        MIn;
  logic [4:0]        EXIn;
  logic [DATA_W-1:0] ReadData1In;
  logic [DATA_W-1:0] ReadData2In;
  logic [DATA_W-1:0] LdAddrIn;
  logic [4:0]        RsIn;
  logic [4:0]        RtIn;
  logic [4:0]        RdIn;
  // Forwarding sources from later stages
  logic              ExMemRegWrite;
  logic [4:0]        ExMemRd;
  logic [DATA_W-1:0] ExMemResult;
  logic              MemWbRegWrite;
  logic [4:0]        MemWbRd;
  logic [DATA_W-1:0] MemWbResult;
  // Hazard output and EX/MEM pipeline fields
  logic              Stall;
  logic [1:0]        WBOut;
  logic [1:0]        MOut;
  logic [DATA_W-1:0] AluResultOut;
  logic [DATA_W-1:0] WriteDataOut;
  logic [4:0]        DstRegOut;
  logic              ZeroOut;

  modport master (
    output WBIn, MIn, EXIn, ReadData1In, ReadData2In, LdAddrIn, RsIn, RtIn, RdIn,
    output ExMemRegWrite, ExMemRd, ExMemResult, MemWbRegWrite, MemWbRd, MemWbResult,
    input  Stall, WBOut, MOut, AluResultOut, WriteDataOut, DstRegOut, ZeroOut
  );

  modport slave (
    input  WBIn, MIn, EXIn, ReadData1In, ReadData2In, LdAddrIn, RsIn, RtIn, RdIn,
    input  ExMemRegWrite, ExMemRd, ExMemResult, MemWbRegWrite, MemWbRd, MemWbResult,
    output Stall, WBOut, MOut, AluResultOut, WriteDataOut, DstRegOut, ZeroOut
  );
endinterface

// File: rtl/ex_stage_unit.sv
// Purpose: EX stage with operand forwarding, ALU and an iterative shift-add multiplier.
// Latency: 1 cycle for single-cycle ops; a multiply lands DATA_W/MUL_STEP + 1 edges after entry.
// Backpressure: combinational Stall freezes PC, IF/ID and ID/EX for DATA_W/MUL_STEP cycles per multiply.
module ex_stage_unit #(
  parameter int DATA_W   = 32,
  parameter int MUL_STEP = 1
) (
  input logic          clk,
  input logic          rst,
  ex_stage_unit_if.slave bus
);

  localparam int N     = DATA_W / MUL_STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t            state;
  state_t            stateNext;
  logic [CNT_W-1:0]  count;

  logic              regDst;
  logic              aluSrc;
  logic [2:0]        aluOp;
  logic [4:0]        dstReg;

  logic [DATA_W-1:0] fwdA;
  logic [DATA_W-1:0] fwdB;
  logic [DATA_W-1:0] aluB;
  logic [DATA_W-1:0] aluRes;

  // Multiplier working registers: multiplicand shifts left, multiplier shifts right
  logic [DATA_W-1:0] mulCand;
  logic [DATA_W-1:0] mulPlier;
  logic [DATA_W-1:0] mulAcc;
  logic [DATA_W-1:0] accNext;
  logic [DATA_W-1:0] storeHold;

  logic              startMul;
  logic              lastStep;

  assign regDst = bus.EXIn[4];
  assign aluSrc = bus.EXIn[3];
  assign aluOp  = bus.EXIn[2:0];
  assign dstReg = regDst ? bus.RdIn : bus.RtIn;

  // Forwarding muxes: the younger EX/MEM result wins over MEM/WB; register 0 never forwards
  always_comb begin
    fwdA = bus.ReadData1In;
    if (bus.ExMemRegWrite && (bus.ExMemRd != 5'd0) && (bus.ExMemRd == bus.RsIn)) begin
      fwdA = bus.ExMemResult;
    end else if (bus.MemWbRegWrite && (bus.MemWbRd != 5'd0) && (bus.MemWbRd == bus.RsIn)) begin
      fwdA = bus.MemWbResult;
    end
    fwdB = bus.ReadData2In;
    if (bus.ExMemRegWrite && (bus.ExMemRd != 5'd0) && (bus.ExMemRd == bus.RtIn)) begin
      fwdB = bus.ExMemResult;
    end else if (bus.MemWbRegWrite && (bus.MemWbRd != 5'd0) && (bus.MemWbRd == bus.RtIn)) begin
      fwdB = bus.MemWbResult;
    end
    aluB = aluSrc ? bus.LdAddrIn : fwdB;
  end

  // Single-cycle ALU; the mul encoding is handled by the iterative datapath
  always_comb begin
    aluRes = '0;
    case (aluOp)
      OP_ADD:  aluRes = fwdA + aluB;
      OP_SUB:  aluRes = fwdA - aluB;
      OP_AND:  aluRes = fwdA & aluB;
      OP_OR:   aluRes = fwdA | aluB;
      OP_SLT:  aluRes = ($signed(fwdA) < $signed(aluB)) ? DATA_W'(1) : '0;
      OP_NOR:  aluRes = ~(fwdA | aluB);
      OP_PASS: aluRes = aluB;
      default: aluRes = '0;
    endcase
  end

  // One shift-add step: accumulate the multiplicand for each of the low MUL_STEP multiplier bits
  always_comb begin
    accNext = mulAcc;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mulPlier[i]) begin
        accNext = accNext + (mulCand << i);
      end
    end
  end

  // Next-state and stall decode; reset overrides everything so Stall is low while rst is high
  always_comb begin
    stateNext = state;
    bus.Stall = 1'b0;
    startMul  = 1'b0;
    lastStep  = 1'b0;
    case (state)
      IDLE: begin
        if (aluOp == OP_MUL) begin
          stateNext = MUL_RUN;
          bus.Stall = 1'b1;
          startMul  = 1'b1;
        end
      end
      MUL_RUN: begin
        if (count == LAST_CNT) begin
          stateNext = IDLE;
          lastStep  = 1'b1;
        end else begin
          bus.Stall = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (rst) begin
      stateNext = IDLE;
      bus.Stall = 1'b0;
      startMul  = 1'b0;
      lastStep  = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Multiplier datapath: operands are latched on entry so forwarding changes cannot disturb them
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      mulCand   <= '0;
      mulPlier  <= '0;
      mulAcc    <= '0;
      storeHold <= '0;
    end else if (startMul) begin
      count     <= '0;
      mulCand   <= fwdA;
      mulPlier  <= aluB;
      mulAcc    <= '0;
      storeHold <= fwdB;
    end else if (state == MUL_RUN) begin
      count    <= count + 1'b1;
      mulCand  <= mulCand << MUL_STEP;
      mulPlier <= mulPlier >> MUL_STEP;
      mulAcc   <= accNext;
    end
  end

  // EX/MEM register: product on the final step, bubbles while multiplying, ALU result otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.WBOut        <= '0;
      bus.MOut         <= '0;
      bus.AluResultOut <= '0;
      bus.WriteDataOut <= '0;
      bus.DstRegOut    <= '0;
      bus.ZeroOut      <= 1'b0;
    end else if (lastStep) begin
      bus.WBOut        <= bus.WBIn;
      bus.MOut         <= bus.MIn;
      bus.AluResultOut <= accNext;
      bus.WriteDataOut <= storeHold;
      bus.DstRegOut    <= dstReg;
      bus.ZeroOut      <= (accNext == '0);
    end else if (startMul || (state == MUL_RUN)) begin
      bus.WBOut        <= '0;
      bus.MOut         <= '0;
      bus.AluResultOut <= '0;
      bus.WriteDataOut <= '0;
      bus.DstRegOut    <= '0;
      bus.ZeroOut      <= 1'b0;
    end else begin
      bus.WBOut        <= bus.WBIn;
      bus.MOut         <= bus.MIn;
      bus.AluResultOut <= aluRes;
      bus.WriteDataOut <= fwdB;
      bus.DstRegOut    <= dstReg;
      bus.ZeroOut      <= (aluRes == '0);
    end
  end

endmodule

// File: tb/tb_ex_stage_unit.sv
// Purpose: directed bench for the EX stage covering ALU ops, forwarding, multiply stall and reset abort.
// Latency: expects 1 cycle for ALU ops and 33 edges for a 32-bit multiply.
// Backpressure: holds ID/EX inputs steady while Stall is high.
module tb_ex_stage_unit;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  ex_stage_unit_if #(.DATA_W(32)) bus ();

  ex_stage_unit #(.DATA_W(32), .MUL_STEP(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setOp(input logic [4:0] ex, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [1:0] wb, input logic [1:0] m);
    bus.EXIn        = ex;
    bus.ReadData1In = a;
    bus.ReadData2In = b;
    bus.LdAddrIn    = imm;
    bus.RsIn        = rs;
    bus.RtIn        = rt;
    bus.RdIn        = rd;
    bus.WBIn        = wb;
    bus.MIn         = m;
  endtask

  task automatic noFwd();
    bus.ExMemRegWrite = 1'b0;
    bus.ExMemRd       = 5'd0;
    bus.ExMemResult   = 32'd0;
    bus.MemWbRegWrite = 1'b0;
    bus.MemWbRd       = 5'd0;
    bus.MemWbResult   = 32'd0;
  endtask

  task automatic chkOut(input string tag, input logic [31:0] res, input logic [4:0] dst,
                        input logic zero, input logic [1:0] wb);
    chk({tag, "_res"},  bus.AluResultOut, res);
    chk({tag, "_dst"},  {27'd0, bus.DstRegOut}, {27'd0, dst});
    chk({tag, "_zero"}, {31'd0, bus.ZeroOut}, {31'd0, zero});
    chk({tag, "_wb"},   {30'd0, bus.WBOut}, {30'd0, wb});
  endtask

  initial begin
    // Reset with a multiply pending on the inputs: Stall must stay low
    rst = 1'b1;
    noFwd();
    bus.ExMemRegWrite = 1'b1;
    bus.ExMemRd       = 5'd7;
    bus.ExMemResult   = 32'hDEAD_BEEF;
    setOp(5'b10101, 32'h1234, 32'h5678, 32'h9, 5'd7, 5'd2, 5'd3, 2'b11, 2'b11);
    #1;
    chk("rst_stall_comb", {31'd0, bus.Stall}, 32'd0);
    tick();
    tick();
    chk("rst_wb",    {30'd0, bus.WBOut}, 32'd0);
    chk("rst_m",     {30'd0, bus.MOut}, 32'd0);
    chk("rst_res",   bus.AluResultOut, 32'd0);
    chk("rst_wdata", bus.WriteDataOut, 32'd0);
    chk("rst_dst",   {27'd0, bus.DstRegOut}, 32'd0);
    chk("rst_zero",  {31'd0, bus.ZeroOut}, 32'd0);
    chk("rst_stall", {31'd0, bus.Stall}, 32'd0);

    // Plain add, RegDst selects Rd
    rst = 1'b0;
    noFwd();
    setOp(5'b10000, 32'd5, 32'd7, 32'd0, 5'd1, 5'd9, 5'd3, 2'b10, 2'b01);
    #1;
    chk("add_stall", {31'd0, bus.Stall}, 32'd0);
    tick();
    chkOut("add", 32'd12, 5'd3, 1'b0, 2'b10);
    chk("add_m",     {30'd0, bus.MOut}, 32'd1);
    chk("add_wdata", bus.WriteDataOut, 32'd7);

    // Forwarding priority: EX/MEM beats MEM/WB on Rs
    bus.ExMemRegWrite = 1'b1;
    bus.ExMemRd       = 5'd4;
    bus.ExMemResult   = 32'd100;
    bus.MemWbRegWrite = 1'b1;
    bus.MemWbRd       = 5'd4;
    bus.MemWbResult   = 32'd200;
    setOp(5'b01000, 32'd0, 32'd33, 32'd1, 5'd4, 5'd5, 5'd6, 2'b01, 2'b00);
    tick();
    chkOut("fwd_exmem", 32'd101, 5'd5, 1'b0, 2'b01);
    chk("fwd_exmem_wdata", bus.WriteDataOut, 32'd33);

    // EX/MEM targeting r0 must not forward; MEM/WB takes over
    bus.ExMemRd = 5'd0;
    tick();
    chk("fwd_memwb_res", bus.AluResultOut, 32'd201);

    // Rt forwarded from MEM/WB into both the B operand and the store data
    setOp(5'b10001, 32'd50, 32'd1, 32'd0, 5'd2, 5'd4, 5'd10, 2'b10, 2'b10);
    tick();
    chkOut("sub_fwdb", 32'hFFFF_FF6A, 5'd10, 1'b0, 2'b10);
    chk("sub_fwdb_wdata", bus.WriteDataOut, 32'd200);

    // Logic ops and zero flag without forwarding
    noFwd();
    setOp(5'b10010, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd1, 5'd2, 5'd11, 2'b10, 2'b00);
    tick();
    chk("and_res", bus.AluResultOut, 32'h0000_F000);
    bus.EXIn = 5'b10011;
    tick();
    chk("or_res", bus.AluResultOut, 32'h0000_FFF0);
    setOp(5'b10110, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2, 5'd11, 2'b10, 2'b00);
    tick();
    chk("nor_res", bus.AluResultOut, 32'hFFFF_FFFF);
    setOp(5'b01111, 32'd77, 32'd88, 32'h1234, 5'd1, 5'd2, 5'd11, 2'b10, 2'b00);
    tick();
    chkOut("passb", 32'h1234, 5'd2, 1'b0, 2'b10);
    setOp(5'b10001, 32'd5, 32'd5, 32'd0, 5'd1, 5'd2, 5'd12, 2'b10, 2'b00);
    tick();
    chkOut("sub_zero", 32'd0, 5'd12, 1'b1, 2'b10);

    // Multiply 6*7 with A forwarded from EX/MEM; the source changes mid-run
    bus.ExMemRegWrite = 1'b1;
    bus.ExMemRd       = 5'd6;
    bus.ExMemResult   = 32'd6;
    setOp(5'b10101, 32'd999, 32'd7, 32'd0, 5'd6, 5'd9, 5'd8, 2'b11, 2'b10);
    #1;
    for (int c = 0; c <= 32; c++) begin
      chk($sformatf("mul1_stall_c%0d", c), {31'd0, bus.Stall}, (c < 32) ? 32'd1 : 32'd0);
      if (c >= 1) begin
        chk($sformatf("mul1_bubble_c%0d", c), {30'd0, bus.WBOut}, 32'd0);
      end
      if (c == 10) begin
        bus.ExMemResult = 32'd1000;
      end
      tick();
    end
    chkOut("mul1", 32'd42, 5'd8, 1'b0, 2'b11);
    chk("mul1_m", {30'd0, bus.MOut}, 32'd2);
    chk("mul1_wdata", bus.WriteDataOut, 32'd7);

    // Back-to-back multiply overflowing to zero, with WBIn = 0
    noFwd();
    setOp(5'b10101, 32'h0001_0000, 32'h0001_0000, 32'd0, 5'd1, 5'd2, 5'd13, 2'b00, 2'b00);
    #1;
    for (int c = 0; c <= 32; c++) begin
      chk($sformatf("mul2_stall_c%0d", c), {31'd0, bus.Stall}, (c < 32) ? 32'd1 : 32'd0);
      tick();
    end
    chkOut("mul2", 32'd0, 5'd13, 1'b1, 2'b00);

    // Signed slt: -1 < 1
    setOp(5'b10100, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd1, 5'd2, 5'd14, 2'b10, 2'b00);
    #1;
    chk("slt_stall", {31'd0, bus.Stall}, 32'd0);
    tick();
    chkOut("slt", 32'd1, 5'd14, 1'b0, 2'b10);

    // Reset at cycle 10 of a multiply aborts it
    setOp(5'b10101, 32'd3, 32'd5, 32'd0, 5'd1, 5'd2, 5'd15, 2'b11, 2'b11);
    for (int c = 0; c < 10; c++) begin
      tick();
    end
    chk("abort_stall_before", {31'd0, bus.Stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_stall_rst", {31'd0, bus.Stall}, 32'd0);
    tick();
    chkOut("abort", 32'd0, 5'd0, 1'b0, 2'b00);
    chk("abort_m", {30'd0, bus.MOut}, 32'd0);
    rst = 1'b0;
    setOp(5'b10000, 32'd10, 32'd20, 32'd0, 5'd1, 5'd2, 5'd16, 2'b10, 2'b01);
    #1;
    chk("abort_idle_stall", {31'd0, bus.Stall}, 32'd0);
    tick();
    chkOut("post_abort_add", 32'd30, 5'd16, 1'b0, 2'b10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
